// File: rtl/fsub_seq.sv
// fsub_seq: iterative IEEE-754 single-precision subtractor, out_data = a - b.
// Computed as a + (-b) on a 27-bit working mantissa (hidden + 23 fraction +
// guard/round/sticky). Alignment and normalization move one bit per cycle.
// Denormal operands and denormal results flush to zero.
//
// Ports:
//   clk        single clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block idle, pair accepted on in_valid && in_ready
//   a, b       minuend / subtrahend (binary32)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_data   a - b (binary32), registered
module fsub_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [2:0] {
    IDLE, UNPK, ALGN, ADDS, NORM, RND, DONE
  } state_t;

  state_t      state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sign_r;
  logic        sub_r;
  logic        zero_r;
  logic [9:0]  exp_r;
  logic [26:0] m_big;
  logic [26:0] m_small;
  logic [4:0]  cnt;

  // Operand classification; sb is the effective (inverted) sign of b.
  logic        sa;
  logic        sb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        a_big;
  logic [7:0]  d;
  logic [4:0]  align_cnt;
  logic        special;
  logic [31:0] special_val;

  always_comb begin
    sa     = a_r[31];
    sb     = ~b_r[31];
    ea     = a_r[30:23];
    eb     = b_r[30:23];
    fa     = a_r[22:0];
    fb     = b_r[22:0];
    nan_a  = (ea == 8'hFF) && (fa != '0);
    nan_b  = (eb == 8'hFF) && (fb != '0);
    inf_a  = (ea == 8'hFF) && (fa == '0);
    inf_b  = (eb == 8'hFF) && (fb == '0);
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);
    // Exponent-then-fraction ordering is the same as comparing bits [30:0].
    a_big  = (a_r[30:0] >= b_r[30:0]);
    d      = a_big ? (ea - eb) : (eb - ea);
    align_cnt = (d > 8'd26) ? 5'd26 : d[4:0];

    special     = 1'b1;
    special_val = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
      special_val = 32'h7FC0_0000;
    else if (inf_a)
      special_val = {sa, 8'hFF, 23'd0};
    else if (inf_b)
      special_val = {sb, 8'hFF, 23'd0};
    else if (zero_a && zero_b)
      special_val = {sa & sb, 31'd0};
    else if (zero_a)
      special_val = {sb, b_r[30:0]};
    else if (zero_b)
      special_val = a_r;
    else
      special = 1'b0;
  end

  // Add/subtract and round datapath.
  logic [27:0] sum;
  logic [23:0] rnd_mant;
  logic        rnd_up;
  logic [24:0] rnd_sum;
  logic [9:0]  rnd_exp;
  logic [22:0] rnd_frac;
  logic [31:0] rnd_val;

  always_comb begin
    sum = sub_r ? ({1'b0, m_big} - {1'b0, m_small})
                : ({1'b0, m_big} + {1'b0, m_small});
    rnd_mant = m_big[26:3];
    // Nearest-even: round up above half, or at exactly half when LSB is odd.
    rnd_up   = m_big[2] & (m_big[1] | m_big[0] | m_big[3]);
    rnd_sum  = {1'b0, rnd_mant} + {24'd0, rnd_up};
    rnd_exp  = exp_r + {9'd0, rnd_sum[24]};
    rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
    if (zero_r)
      rnd_val = '0;
    else if (rnd_exp >= 10'd255)
      rnd_val = {sign_r, 8'hFF, 23'd0};
    else
      rnd_val = {sign_r, rnd_exp[7:0], rnd_frac};
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      sub_r     <= 1'b0;
      zero_r    <= 1'b0;
      exp_r     <= '0;
      m_big     <= '0;
      m_small   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            state <= UNPK;
          end
        end
        UNPK: begin
          if (special) begin
            out_data  <= special_val;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sign_r  <= a_big ? sa : sb;
            sub_r   <= sa ^ sb;
            zero_r  <= 1'b0;
            exp_r   <= {2'b00, (a_big ? ea : eb)};
            m_big   <= {1'b1, (a_big ? fa : fb), 3'b000};
            m_small <= {1'b1, (a_big ? fb : fa), 3'b000};
            cnt     <= align_cnt;
            state   <= (d != 8'd0) ? ALGN : ADDS;
          end
        end
        ALGN: begin
          // Bits leaving position 0 are folded into sticky; after 26 steps
          // only the sticky bit of the smaller operand can remain.
          m_small <= {1'b0, m_small[26:2], m_small[1] | m_small[0]};
          cnt     <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= ADDS;
        end
        ADDS: begin
          if (sum[27]) begin
            m_big <= {sum[27:2], sum[1] | sum[0]};
            exp_r <= exp_r + 10'd1;
            state <= RND;
          end else if (sum == '0) begin
            zero_r <= 1'b1;
            state  <= RND;
          end else begin
            m_big <= sum[26:0];
            state <= sum[26] ? RND : NORM;
          end
        end
        NORM: begin
          m_big <= {m_big[25:0], 1'b0};
          exp_r <= exp_r - 10'd1;
          if (exp_r == 10'd1) begin
            zero_r <= 1'b1;
            state  <= RND;
          end else if (m_big[25]) begin
            state <= RND;
          end
        end
        RND: begin
          out_data  <= rnd_val;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsub_seq.sv
module tb_fsub_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  fsub_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer difference, then round-to-nearest-even into
  // binary32 with flush-to-zero; latency from exponent bookkeeping.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    logic         xs, ys, rs;
    int           xe, ye, el, es, d, p, sh, ep, z;
    logic [299:0] xm, ym, mag, keep, rem, half;
    xs  = x[31];
    ys  = ~y[31];
    xe  = {24'd0, x[30:23]};
    ye  = {24'd0, y[30:23]};
    lat = 2;
    res = '0;
    if ((xe == 255 && x[22:0] != 0) || (ye == 255 && y[22:0] != 0) ||
        (xe == 255 && ye == 255 && xs != ys))
      res = 32'h7FC00000;
    else if (xe == 255) res = {xs, 8'hFF, 23'd0};
    else if (ye == 255) res = {ys, 8'hFF, 23'd0};
    else if (xe == 0 && ye == 0) res = (xs && ys) ? 32'h80000000 : 32'h0;
    else if (xe == 0) res = {ys, y[30:0]};
    else if (ye == 0) res = x;
    else begin
      el = (xe > ye) ? xe : ye;
      es = (xe > ye) ? ye : xe;
      d  = el - es;
      xm = {276'd0, 1'b1, x[22:0]} << (xe - es);
      ym = {276'd0, 1'b1, y[22:0]} << (ye - es);
      if (xs == ys) begin mag = xm + ym; rs = xs; end
      else if (xm >= ym) begin mag = xm - ym; rs = xs; end
      else begin mag = ym - xm; rs = ys; end
      if (mag == '0) begin
        res = '0;
        lat = 4 + d;
      end else begin
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        ep = es + p - 23;
        z  = el - ep;
        if (z < 0) z = 0;
        if (z > el) z = el;
        lat = 4 + ((d > 26) ? 26 : d) + z;
        if (ep <= 0) res = '0;
        else begin
          if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
            if (keep[24]) begin keep = keep >> 1; ep++; end
          end else begin
            keep = mag << (23 - p);
          end
          if (ep >= 255) res = {rs, 8'hFF, 23'd0};
          else res = {rs, ep[7:0], keep[22:0]};
        end
      end
    end
  endtask

  function automatic logic [31:0] mkf(input logic s, input int e, input logic [22:0] f);
    int ec;
    ec = e;
    if (ec < 1) ec = 1;
    if (ec > 254) ec = 254;
    return {s, ec[7:0], f};
  endfunction

  // Issue one pair from an idle DUT, wait for the result, complete handshake.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output bit ok);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ok  = out_valid;
    res = out_data;
    if (ok) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    // Async reset while a result is being held.
    a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h40000000}) begin
      errors++; $display("FAIL reset_pre_hold got v=%b d=%h exp v=1 d=40000000", out_valid, out_data);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL reset_async_done got v=%b d=%h r=%b exp v=0 d=00000000 r=1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] opa [6] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] opb [6] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h33800000, 32'h33000000, 32'h00400000};
    logic [31:0] exv [6] = '{32'h40000000, 32'h40000000, 32'h00000000, 32'h3F7FFFFF, 32'h3F800000, 32'h3F800000};
    int          exl [6] = '{5, 4, 4, 29, 30, 2};
    logic [31:0] res;
    int          lat;
    bit          ok;
    for (int i = 0; i < 6; i++) begin
      run_op(opa[i], opb[i], res, lat, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL directed_timeout case %0d no out_valid within bound", i); end
      checks++;
      if (res !== exv[i]) begin errors++; $display("FAIL directed_value case %0d got %h exp %h", i, res, exv[i]); end
      checks++;
      if (lat != exl[i]) begin errors++; $display("FAIL directed_latency case %0d got %0d exp %0d", i, lat, exl[i]); end
    end
  endtask

  task automatic test_backpressure;
    a = 32'h7F800000; b = 32'h7F800000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h7FC00000}) begin
      errors++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=7fc00000", out_valid, out_data);
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; in_valid = i[0];
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 32'h7FC00000}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b r=%b d=%h exp v=1 r=0 d=7fc00000", i, out_valid, in_ready, out_data);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_stay_idle got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b1;
    a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'hBF800000;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_data !== 32'h40000000) begin errors++; $display("FAIL b2b_first_value got %h exp 40000000", out_data); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL b2b_first_latency got %0d exp 5", lat); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL b2b_pass_idle got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got r=%b exp 0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_data !== 32'h40000000) begin errors++; $display("FAIL b2b_second_value got %h exp 40000000", out_data); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL b2b_second_latency got %0d exp 4", lat); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] res;
    int          lat;
    bit          ok;
    a = 32'h3F800000; b = 32'h33800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL midop_reset got v=%b d=%h r=%b exp v=0 d=00000000 r=1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL midop_discard got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    run_op(32'h40400000, 32'h3F800000, res, lat, ok);
    checks++;
    if (!ok || res !== 32'h40000000) begin errors++; $display("FAIL midop_after_value got %h exp 40000000", res); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL midop_after_latency got %0d exp 5", lat); end
  endtask

  task automatic test_random;
    logic [31:0] sp [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                            32'h7FC00000, 32'h7F800001, 32'h00400000, 32'h80012345};
    logic [31:0] x, y, t, res, exv;
    logic [22:0] f0, f1;
    logic        s0, s1;
    int          cls, e0, off, lat, exl;
    bit          ok;
    for (int i = 0; i < 200; i++) begin
      cls = $urandom_range(0, 5);
      s0  = 1'($urandom);
      s1  = 1'($urandom);
      e0  = $urandom_range(1, 254);
      f0  = 23'($urandom);
      f1  = 23'($urandom);
      off = $urandom_range(0, 6);
      off = off - 3;
      case (cls)
        0: begin x = mkf(s0, e0, f0); y = mkf(s1, e0 + off, f1); end
        1: begin
          off = $urandom_range(0, 80);
          off = off - 40;
          x = mkf(s0, e0, f0); y = mkf(s1, e0 + off, f1);
        end
        2: begin
          x = mkf(s0, e0, f0);
          y = x ^ {9'd0, 23'($urandom_range(1, 4095))};
          if ($urandom_range(0, 1) == 1) y = mkf(s0, e0 - 1, f1);
        end
        3: begin
          x = sp[$urandom_range(0, 7)];
          y = mkf(s1, e0, f1);
          if ($urandom_range(0, 1) == 1) y = sp[$urandom_range(0, 7)];
          if ($urandom_range(0, 1) == 1) begin t = x; x = y; y = t; end
        end
        4: begin x = mkf(s0, $urandom_range(1, 4), f0); y = mkf(s0, $urandom_range(1, 4), f1); end
        default: begin
          x = mkf(1'b0, $urandom_range(252, 254), f0);
          y = mkf(1'b1, $urandom_range(252, 254), f1);
        end
      endcase
      model(x, y, exv, exl);
      run_op(x, y, res, lat, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL random_timeout a=%h b=%h no out_valid within bound", x, y); end
      checks++;
      if (res !== exv) begin errors++; $display("FAIL random_value a=%h b=%h got %h exp %h", x, y, res, exv); end
      checks++;
      if (lat != exl) begin errors++; $display("FAIL random_latency a=%h b=%h got %0d exp %0d", x, y, lat, exl); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
